// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the pipelined RISC-V core.
//   XLEN            datapath width (only 32 is supported)
//   wb_sel_e        writeback result select: WB_ALU, WB_LOAD, WB_PC4, WB_ZERO
//   F3_*            load size/sign funct3 encodings
//   mem_wb_t        MEM/WB pipeline register contents
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    wb_sel_e         wb_sel;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] pc_plus4;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side inputs and WB-side outputs of the MEM/WB stage.
//   master: pipeline control / MEM stage side (drives stall, flush, mem_*)
//   slave : mem_wb_stage (drives reg_write, rd, wd, wb_valid, retire_count)
interface mem_wb_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic            stall;
  logic            flush;
  logic            mem_valid;
  logic            mem_reg_write;
  logic [4:0]      mem_rd;
  logic [1:0]      mem_wb_sel;
  logic [2:0]      mem_funct3;
  logic [1:0]      mem_addr_lo;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_load_data;
  logic [XLEN-1:0] mem_pc_plus4;

  logic            reg_write;
  logic [4:0]      rd;
  logic [XLEN-1:0] wd;
  logic            wb_valid;
  logic [63:0]     retire_count;

  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
           mem_funct3, mem_addr_lo, mem_alu_result, mem_load_data, mem_pc_plus4,
    input  reg_write, rd, wd, wb_valid, retire_count
  );

  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
           mem_funct3, mem_addr_lo, mem_alu_result, mem_load_data, mem_pc_plus4,
    output reg_write, rd, wd, wb_valid, retire_count
  );
endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// load_extract: combinational load-data extraction and extension.
//   funct3  in  3   load size/sign encoding (LB/LH/LW/LBU/LHU, others = word)
//   addr_lo in  2   byte offset within the aligned word
//   word    in  32  raw aligned word from data memory
//   value   out 32  extracted, sign/zero-extended result
module load_extract
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // addr_lo[0] is ignored for halfwords; misalignment is caught upstream
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    value = word;
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  value = {24'd0, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  value = {16'd0, half_sel};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback select.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of mem_wb_stage_if (MEM inputs, regfile write port,
//        wb_valid, retire_count)
// Optional feature: define MEM_WB_RETIRE_CNT_EN to build the 64-bit
// retired-instruction counter; otherwise retire_count is tied to 0.
module mem_wb_stage
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  mem_wb_t         q;
  logic [XLEN-1:0] load_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bus.flush) begin
      q <= '0;
    end else if (!bus.stall) begin
      q.valid      <= bus.mem_valid;
      q.reg_write  <= bus.mem_reg_write;
      q.rd         <= bus.mem_rd;
      q.wb_sel     <= wb_sel_e'(bus.mem_wb_sel);
      q.funct3     <= bus.mem_funct3;
      q.addr_lo    <= bus.mem_addr_lo;
      q.alu_result <= bus.mem_alu_result;
      q.load_data  <= bus.mem_load_data;
      q.pc_plus4   <= bus.mem_pc_plus4;
    end
  end

  load_extract u_load_extract (
    .funct3  (q.funct3),
    .addr_lo (q.addr_lo),
    .word    (q.load_data),
    .value   (load_value)
  );

  always_comb begin
    bus.wd = '0;
    case (q.wb_sel)
      WB_ALU:  bus.wd = q.alu_result;
      WB_LOAD: bus.wd = load_value;
      WB_PC4:  bus.wd = q.pc_plus4;
      default: bus.wd = '0;
    endcase
  end

  // x0 is never written, so it also never appears on the forwarding path
  assign bus.reg_write = q.valid & q.reg_write & (q.rd != 5'd0);
  assign bus.rd        = q.rd;
  assign bus.wb_valid  = q.valid;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
  logic        retire;

  // an instruction retires in the cycle it leaves WB: not held by stall,
  // or pushed out by a flush
  assign retire = q.valid & (~bus.stall | bus.flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end

  assign bus.retire_count = retire_cnt;
`else
  assign bus.retire_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit        rw;
    bit [4:0]  rd;
    bit [1:0]  sel;
    bit [2:0]  f3;
    bit [1:0]  lo;
    bit [31:0] alu;
    bit [31:0] ld;
    bit [31:0] pc4;
  } ins_t;

  typedef struct {
    ins_t      in;
    bit        e_rw;
    bit [4:0]  e_rd;
    bit [31:0] e_wd;
    bit        e_v;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  ins_t            m_slot;
  longint unsigned m_cnt;
  ins_t            bubble;

  function automatic ins_t mk(bit v, bit rw, bit [4:0] rd, bit [1:0] sel, bit [2:0] f3,
                              bit [1:0] lo, bit [31:0] alu, bit [31:0] ld, bit [31:0] pc4);
    ins_t i;
    i.valid = v; i.rw = rw; i.rd = rd; i.sel = sel; i.f3 = f3; i.lo = lo;
    i.alu = alu; i.ld = ld; i.pc4 = pc4;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    return mk(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
              2'($urandom), $urandom, $urandom, $urandom);
  endfunction

  // Reference writeback value, from the load rules with plain arithmetic
  function automatic bit [31:0] model_wd(ins_t i);
    int unsigned b, h;
    b = (i.ld >> (8 * i.lo)) & 32'hFF;
    h = (i.ld >> (16 * (i.lo / 2))) & 32'hFFFF;
    case (i.sel)
      2'd0: return i.alu;
      2'd2: return i.pc4;
      2'd3: return 32'd0;
      default: begin
        case (i.f3)
          3'd0:    return (b >= 128) ? b - 32'd256 : b;
          3'd4:    return b;
          3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
          3'd5:    return h;
          default: return i.ld;
        endcase
      end
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, advance the model, and land 1 ns past the edge
  task automatic step(ins_t s, bit st, bit fl);
    bit retire;
    bus.stall          = st;
    bus.flush          = fl;
    bus.mem_valid      = s.valid;
    bus.mem_reg_write  = s.rw;
    bus.mem_rd         = s.rd;
    bus.mem_wb_sel     = s.sel;
    bus.mem_funct3     = s.f3;
    bus.mem_addr_lo    = s.lo;
    bus.mem_alu_result = s.alu;
    bus.mem_load_data  = s.ld;
    bus.mem_pc_plus4   = s.pc4;
    retire = m_slot.valid && (!st || fl);
    if (fl) m_slot = bubble;
    else if (!st) m_slot = s;
`ifdef MEM_WB_RETIRE_CNT_EN
    if (retire) m_cnt++;
`else
    if (retire) m_cnt = m_cnt;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(string tag);
    check({tag, ".reg_write"}, 64'(bus.reg_write),
          64'(m_slot.valid && m_slot.rw && (m_slot.rd != 0)));
    check({tag, ".rd"}, 64'(bus.rd), 64'(m_slot.rd));
    check({tag, ".wd"}, 64'(bus.wd), 64'(model_wd(m_slot)));
    check({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'(m_slot.valid));
    check({tag, ".retire_count"}, bus.retire_count, m_cnt);
  endtask

  function automatic longint unsigned cnt_exp(longint unsigned c);
`ifdef MEM_WB_RETIRE_CNT_EN
    return c;
`else
    return (c == 0) ? 0 : 0;
`endif
  endfunction

  vec_t vecs[13];

  initial begin
    longint unsigned c0;
    bubble = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_slot = bubble;
    m_cnt  = 0;
    bus.stall = 0; bus.flush = 0; bus.mem_valid = 0; bus.mem_reg_write = 0;
    bus.mem_rd = 0; bus.mem_wb_sel = 0; bus.mem_funct3 = 0; bus.mem_addr_lo = 0;
    bus.mem_alu_result = 0; bus.mem_load_data = 0; bus.mem_pc_plus4 = 0;

    vecs[0]  = '{mk(1,1,7,1,3'b000,3,0,32'h80FF_1234,0), 1, 7, 32'hFFFF_FF80, 1};
    vecs[1]  = '{mk(1,1,8,1,3'b101,2,0,32'h8001_7FFF,0), 1, 8, 32'h0000_8001, 1};
    vecs[2]  = '{mk(1,1,8,1,3'b001,2,0,32'h8001_7FFF,0), 1, 8, 32'hFFFF_8001, 1};
    vecs[3]  = '{mk(1,1,1,2,0,0,32'h55,0,32'h0000_0104), 1, 1, 32'h0000_0104, 1};
    vecs[4]  = '{mk(1,1,0,2,0,0,32'h55,0,32'h0000_0104), 0, 0, 32'h0000_0104, 1};
    vecs[5]  = '{mk(1,1,2,1,3'b100,1,0,32'h80FF_1234,0), 1, 2, 32'h0000_0012, 1};
    vecs[6]  = '{mk(1,1,3,1,3'b010,0,0,32'h80FF_1234,0), 1, 3, 32'h80FF_1234, 1};
    vecs[7]  = '{mk(1,1,4,1,3'b011,2,0,32'h80FF_1234,0), 1, 4, 32'h80FF_1234, 1};
    vecs[8]  = '{mk(1,1,5,1,3'b001,3,0,32'h8001_7FFF,0), 1, 5, 32'hFFFF_8001, 1};
    vecs[9]  = '{mk(1,1,6,1,3'b000,0,0,32'h80FF_1234,0), 1, 6, 32'h0000_0034, 1};
    vecs[10] = '{mk(1,1,3,3,0,0,32'hFFFF_FFFF,32'hFFFF_FFFF,32'hFFFF_FFFF), 1, 3, 32'h0, 1};
    vecs[11] = '{mk(0,1,4,0,0,0,32'h1234_5678,0,0), 0, 4, 32'h1234_5678, 0};
    vecs[12] = '{mk(1,1,9,0,0,0,32'hDEAD_BEEF,0,0), 1, 9, 32'hDEAD_BEEF, 1};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("reset.reg_write", 64'(bus.reg_write), 0);
    check("reset.rd", 64'(bus.rd), 0);
    check("reset.wd", 64'(bus.wd), 0);
    check("reset.wb_valid", 64'(bus.wb_valid), 0);
    check("reset.retire_count", bus.retire_count, 0);
    rst = 0;

    // Directed vectors
    foreach (vecs[k]) begin
      step(vecs[k].in, 0, 0);
      check($sformatf("vec%0d.reg_write", k), 64'(bus.reg_write), 64'(vecs[k].e_rw));
      check($sformatf("vec%0d.rd", k), 64'(bus.rd), 64'(vecs[k].e_rd));
      check($sformatf("vec%0d.wd", k), 64'(bus.wd), 64'(vecs[k].e_wd));
      check($sformatf("vec%0d.wb_valid", k), 64'(bus.wb_valid), 64'(vecs[k].e_v));
    end
    check("vecs.retire_count", bus.retire_count, cnt_exp(longint'(11)));

    // Stall holds DEADBEEF while inputs change; retire once when stall drops
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(rand_ins(), 1, 0);
      check($sformatf("stall%0d.wd", i), 64'(bus.wd), 64'h0000_0000_DEAD_BEEF);
      check($sformatf("stall%0d.rd", i), 64'(bus.rd), 9);
      check($sformatf("stall%0d.reg_write", i), 64'(bus.reg_write), 1);
      check($sformatf("stall%0d.retire_count", i), bus.retire_count, cnt_exp(c0));
    end
    step(mk(1,1,10,0,0,0,32'h0000_0042,0,0), 0, 0);
    check("unstall.wd", 64'(bus.wd), 64'h42);
    check("unstall.retire_count", bus.retire_count, cnt_exp(c0 + 1));

    // Flush and stall together load a bubble
    step(mk(1,1,11,0,0,0,32'h1111_2222,0,0), 1, 1);
    check("flush_stall.wb_valid", 64'(bus.wb_valid), 0);
    check("flush_stall.reg_write", 64'(bus.reg_write), 0);
    check("flush_stall.retire_count", bus.retire_count, cnt_exp(c0 + 2));

    // Asynchronous reset mid-cycle
    step(mk(1,1,12,2,0,0,0,0,32'hCAFE_0000), 0, 0);
    check("pre_rst.wd", 64'(bus.wd), 64'hCAFE_0000);
    #2 rst = 1;
    #1;
    check("async_rst.reg_write", 64'(bus.reg_write), 0);
    check("async_rst.rd", 64'(bus.rd), 0);
    check("async_rst.wd", 64'(bus.wd), 0);
    check("async_rst.wb_valid", 64'(bus.wb_valid), 0);
    check("async_rst.retire_count", bus.retire_count, 0);
    #1 rst = 0;
    m_slot = bubble;
    m_cnt  = 0;

    // 5 valid, 2 bubbles, 1 store, then a bubble to push the store out
    for (int i = 0; i < 5; i++) step(mk(1,1,5'(i+1),0,0,0,32'(i),0,0), 0, 0);
    step(bubble, 0, 0);
    step(bubble, 0, 0);
    step(mk(1,0,0,0,0,0,32'h100,0,0), 0, 0);
    step(bubble, 0, 0);
    check("count6.retire_count", bus.retire_count, cnt_exp(longint'(6)));

`ifdef MEM_WB_RETIRE_CNT_EN
    // Wrap from 2^64-1 to 0
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step(bubble, 0, 0);
    release dut.retire_cnt;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    check("preload.retire_count", bus.retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
    step(mk(1,1,1,0,0,0,32'h7,0,0), 0, 0);
    step(bubble, 0, 0);
    check("wrap.retire_count", bus.retire_count, 64'h0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bit st, fl;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      step(rand_ins(), st, fl);
      compare_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
